uc_fsm: RTL and testbench

Multicycle control unit that sequences fetch, decode, execute, memory and write-back for the datapath. It generates every datapath select and write enable. This includes `S_MXSE`, which steers the ALU B operand between the register-file output `in_RB` (0) and the sign-extended immediate `in_SE` (1). It sits between the instruction/data memory handshake and the datapath muxes and registers.

---
 rtl/uc_pkg.sv | 23 ++
 rtl/uc_out_dec.sv | 99 +++++++++
 rtl/uc_fsm.sv | 96 +++++++++
 tb/tb_uc_fsm.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared opcode, state and ALU constants for the multicycle control unit.
package uc_pkg;

    localparam logic [4:0] OP_NOP   = 5'd0;
    localparam logic [4:0] OP_ALU_R = 5'd1;
    localparam logic [4:0] OP_ALU_I = 5'd2;
    localparam logic [4:0] OP_LOAD  = 5'd3;
    localparam logic [4:0] OP_STORE = 5'd4;
    localparam logic [4:0] OP_JUMP  = 5'd5;
    localparam logic [4:0] OP_HALT  = 5'd31;

    localparam logic [3:0] ALU_ADD = 4'b0000;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

endpackage

// File: rtl/uc_out_dec.sv
// Combinational map from control state, latched opcode/funct and memory
// handshake to every datapath select and write enable.
module uc_out_dec
    import uc_pkg::*;
#(
    parameter int OPW = 5,
    parameter int FNW = 4
) (
    input  logic           rst_n,
    input  state_t         state,
    input  logic [OPW-1:0] op,
    input  logic [FNW-1:0] funct,
    input  logic           mem_ready,
    output logic           MEM_RD,
    output logic           MEM_WR,
    output logic           S_MXSE,
    output logic           S_MXWB,
    output logic           S_MXPC,
    output logic           W_PC,
    output logic           W_IR,
    output logic           W_RF,
    output logic [FNW-1:0] ALU_OP,
    output logic           illegal,
    output logic           halted
);

    logic           op_legal;
    logic           alu_se;
    logic [FNW-1:0] alu_fn;

    // ALU operand/function set up in EXEC and held through MEM/WB
    always_comb begin
        op_legal = 1'b1;
        alu_se   = 1'b0;
        alu_fn   = '0;
        case (op)
            OPW'(OP_NOP), OPW'(OP_JUMP), OPW'(OP_HALT): ;
            OPW'(OP_ALU_R): alu_fn = funct;
            OPW'(OP_ALU_I): begin
                alu_se = 1'b1;
                alu_fn = funct;
            end
            OPW'(OP_LOAD), OPW'(OP_STORE): begin
                alu_se = 1'b1;
                alu_fn = FNW'(ALU_ADD);
            end
            default: op_legal = 1'b0;
        endcase
    end

    always_comb begin
        MEM_RD  = 1'b0;
        MEM_WR  = 1'b0;
        S_MXSE  = 1'b0;
        S_MXWB  = 1'b0;
        S_MXPC  = 1'b0;
        W_PC    = 1'b0;
        W_IR    = 1'b0;
        W_RF    = 1'b0;
        ALU_OP  = '0;
        illegal = 1'b0;
        halted  = 1'b0;
        if (rst_n) begin
            case (state)
                FETCH: begin
                    MEM_RD = 1'b1;
                    if (mem_ready) begin
                        W_IR = 1'b1;
                        W_PC = 1'b1;
                    end
                end
                DECODE: illegal = !op_legal;
                EXEC: begin
                    S_MXSE = alu_se;
                    ALU_OP = alu_fn;
                    if (op == OPW'(OP_JUMP)) begin
                        W_PC   = 1'b1;
                        S_MXPC = 1'b1;
                    end
                end
                MEM: begin
                    MEM_RD = (op == OPW'(OP_LOAD));
                    MEM_WR = (op == OPW'(OP_STORE));
                    S_MXSE = 1'b1;
                    ALU_OP = FNW'(ALU_ADD);
                end
                WB: begin
                    W_RF   = 1'b1;
                    S_MXWB = (op == OPW'(OP_LOAD));
                    S_MXSE = alu_se;
                    ALU_OP = alu_fn;
                end
                HALT:    halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uc_fsm.sv
// Multicycle control unit: state, opcode and funct registers plus next-state
// sequencing; all outputs come from uc_out_dec.
module uc_fsm
    import uc_pkg::*;
#(
    parameter int OPW = 5,
    parameter int FNW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [31:0]    instr,
    input  logic           mem_ready,
    output logic           MEM_RD,
    output logic           MEM_WR,
    output logic           S_MXSE,
    output logic           S_MXWB,
    output logic           S_MXPC,
    output logic           W_PC,
    output logic           W_IR,
    output logic           W_RF,
    output logic [FNW-1:0] ALU_OP,
    output logic           illegal,
    output logic           halted
);

    state_t         state;
    logic [OPW-1:0] op_q;
    logic [FNW-1:0] funct_q;
    logic           unused_instr_bits;

    assign unused_instr_bits = ^instr[31-OPW-FNW:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= FETCH;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        op_q    <= instr[31 -: OPW];
                        funct_q <= instr[31-OPW -: FNW];
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    // the decoder's illegal flag doubles as the legality test here
                    if (op_q == OPW'(OP_HALT))
                        state <= HALT;
                    else if (op_q == OPW'(OP_NOP) || illegal)
                        state <= FETCH;
                    else
                        state <= EXEC;
                end
                EXEC: begin
                    case (op_q)
                        OPW'(OP_ALU_R), OPW'(OP_ALU_I): state <= WB;
                        OPW'(OP_LOAD), OPW'(OP_STORE):  state <= MEM;
                        default:                        state <= FETCH;
                    endcase
                end
                MEM: begin
                    if (mem_ready)
                        state <= (op_q == OPW'(OP_LOAD)) ? WB : FETCH;
                end
                WB:      state <= FETCH;
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    uc_out_dec #(
        .OPW(OPW),
        .FNW(FNW)
    ) u_out_dec (
        .rst_n    (rst_n),
        .state    (state),
        .op       (op_q),
        .funct    (funct_q),
        .mem_ready(mem_ready),
        .MEM_RD   (MEM_RD),
        .MEM_WR   (MEM_WR),
        .S_MXSE   (S_MXSE),
        .S_MXWB   (S_MXWB),
        .S_MXPC   (S_MXPC),
        .W_PC     (W_PC),
        .W_IR     (W_IR),
        .W_RF     (W_RF),
        .ALU_OP   (ALU_OP),
        .illegal  (illegal),
        .halted   (halted)
    );

endmodule

// File: tb/tb_uc_fsm.sv
// Directed self-checking bench for uc_fsm: per-cycle output vectors per scenario.
module tb_uc_fsm;
    import uc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_ready;
    logic        MEM_RD, MEM_WR, S_MXSE, S_MXWB, S_MXPC, W_PC, W_IR, W_RF;
    logic [3:0]  ALU_OP;
    logic        illegal, halted;
    logic [13:0] outv;

    int checks = 0;
    int errors = 0;

    localparam logic [13:0] RD  = 14'h2000;
    localparam logic [13:0] WR  = 14'h1000;
    localparam logic [13:0] SE  = 14'h0800;
    localparam logic [13:0] WBS = 14'h0400;
    localparam logic [13:0] PCS = 14'h0200;
    localparam logic [13:0] WPC = 14'h0100;
    localparam logic [13:0] WIR = 14'h0080;
    localparam logic [13:0] WRF = 14'h0040;
    localparam logic [13:0] ILL = 14'h0002;
    localparam logic [13:0] HLT = 14'h0001;
    localparam logic [13:0] FET = RD | WIR | WPC;
    localparam logic [31:0] JUNK = 32'hFFFF_FFFF;

    always #5 clk = ~clk;

    assign outv = {MEM_RD, MEM_WR, S_MXSE, S_MXWB, S_MXPC, W_PC, W_IR, W_RF,
                   ALU_OP, illegal, halted};

    uc_fsm #(
        .OPW(5),
        .FNW(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .instr    (instr),
        .mem_ready(mem_ready),
        .MEM_RD   (MEM_RD),
        .MEM_WR   (MEM_WR),
        .S_MXSE   (S_MXSE),
        .S_MXWB   (S_MXWB),
        .S_MXPC   (S_MXPC),
        .W_PC     (W_PC),
        .W_IR     (W_IR),
        .W_RF     (W_RF),
        .ALU_OP   (ALU_OP),
        .illegal  (illegal),
        .halted   (halted)
    );

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] fn);
        return {op, fn, 23'b0};
    endfunction

    function automatic logic [13:0] aop(input logic [3:0] fn);
        return {8'b0, fn, 2'b0};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        instr = mk(OP_ALU_R, 4'd1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (outv !== 14'h0) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", outv, 14'h0);
        end
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (outv !== RD) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", outv, RD);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alu_r();
        logic [31:0] iv [5] = '{mk(OP_ALU_R, 4'd1), JUNK, JUNK, JUNK, JUNK};
        logic        rv [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [13:0] ev [5] = '{FET, 14'h0, aop(4'd1), WRF | aop(4'd1), RD};
        for (int i = 0; i < 5; i++) begin
            instr = iv[i]; mem_ready = rv[i]; #1;
            checks++;
            if (outv !== ev[i]) begin
                errors++;
                $display("FAIL alu_r cycle %0d: got %h expected %h", i + 1, outv, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu_i();
        logic [31:0] iv [5] = '{mk(OP_ALU_I, 4'd3), JUNK, JUNK, JUNK, JUNK};
        logic        rv [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [13:0] ev [5] = '{FET, 14'h0, SE | aop(4'd3), WRF | SE | aop(4'd3), RD};
        for (int i = 0; i < 5; i++) begin
            instr = iv[i]; mem_ready = rv[i]; #1;
            checks++;
            if (outv !== ev[i]) begin
                errors++;
                $display("FAIL alu_i cycle %0d: got %h expected %h", i + 1, outv, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_wait();
        logic [31:0] iv [8] = '{mk(OP_LOAD, 4'd9), JUNK, JUNK, JUNK, JUNK, JUNK, JUNK, JUNK};
        logic        rv [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [13:0] ev [8] = '{FET, 14'h0, SE, RD | SE, RD | SE, RD | SE, WRF | WBS | SE, RD};
        for (int i = 0; i < 8; i++) begin
            instr = iv[i]; mem_ready = rv[i]; #1;
            checks++;
            if (outv !== ev[i]) begin
                errors++;
                $display("FAIL load_wait cycle %0d: got %h expected %h", i + 1, outv, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store();
        logic [31:0] iv [5] = '{mk(OP_STORE, 4'd5), JUNK, JUNK, JUNK, JUNK};
        logic        rv [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [13:0] ev [5] = '{FET, 14'h0, SE, WR | SE, RD};
        for (int i = 0; i < 5; i++) begin
            instr = iv[i]; mem_ready = rv[i]; #1;
            checks++;
            if (outv !== ev[i]) begin
                errors++;
                $display("FAIL store cycle %0d: got %h expected %h", i + 1, outv, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store_reset();
        logic [31:0] iv [3] = '{mk(OP_STORE, 4'd0), JUNK, JUNK};
        logic [13:0] ev [3] = '{FET, 14'h0, SE};
        for (int i = 0; i < 3; i++) begin
            instr = iv[i]; mem_ready = 1'b1; #1;
            checks++;
            if (outv !== ev[i]) begin
                errors++;
                $display("FAIL store_rst cycle %0d: got %h expected %h", i + 1, outv, ev[i]);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0; #1;
        checks++;
        if (outv !== (WR | SE)) begin
            errors++;
            $display("FAIL store_rst mem: got %h expected %h", outv, WR | SE);
        end
        rst_n = 1'b0; #1;
        checks++;
        if (outv !== 14'h0) begin
            errors++;
            $display("FAIL store_rst drop: got %h expected %h", outv, 14'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (outv !== RD) begin
                errors++;
                $display("FAIL store_rst after %0d: got %h expected %h", i, outv, RD);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jump();
        logic [31:0] iv [4] = '{mk(OP_JUMP, 4'd7), JUNK, JUNK, JUNK};
        logic        rv [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [13:0] ev [4] = '{FET, 14'h0, WPC | PCS, RD};
        for (int i = 0; i < 4; i++) begin
            instr = iv[i]; mem_ready = rv[i]; #1;
            checks++;
            if (outv !== ev[i]) begin
                errors++;
                $display("FAIL jump cycle %0d: got %h expected %h", i + 1, outv, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal_nop();
        logic [31:0] iv [7] = '{mk(5'd7, 4'd2), JUNK, JUNK, mk(OP_NOP, 4'd0), mk(OP_NOP, 4'd0), JUNK, JUNK};
        logic        rv [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [13:0] ev [7] = '{FET, ILL, RD, RD, FET, 14'h0, RD};
        for (int i = 0; i < 7; i++) begin
            instr = iv[i]; mem_ready = rv[i]; #1;
            checks++;
            if (outv !== ev[i]) begin
                errors++;
                $display("FAIL illegal_nop cycle %0d: got %h expected %h", i + 1, outv, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] iv [9] = '{mk(OP_ALU_R, 4'd2), JUNK, JUNK, JUNK,
                                mk(OP_STORE, 4'd6), JUNK, JUNK, JUNK, JUNK};
        logic        rv [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [13:0] ev [9] = '{FET, 14'h0, aop(4'd2), WRF | aop(4'd2),
                                FET, 14'h0, SE, WR | SE, RD};
        for (int i = 0; i < 9; i++) begin
            instr = iv[i]; mem_ready = rv[i]; #1;
            checks++;
            if (outv !== ev[i]) begin
                errors++;
                $display("FAIL b2b cycle %0d: got %h expected %h", i + 1, outv, ev[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt();
        logic [31:0] iv [2] = '{mk(OP_HALT, 4'd0), JUNK};
        logic [13:0] ev [2] = '{FET, 14'h0};
        for (int i = 0; i < 2; i++) begin
            instr = iv[i]; mem_ready = 1'b1; #1;
            checks++;
            if (outv !== ev[i]) begin
                errors++;
                $display("FAIL halt entry %0d: got %h expected %h", i + 1, outv, ev[i]);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 12; i++) begin
            instr = $urandom; mem_ready = 1'(i % 2); #1;
            checks++;
            if (outv !== HLT) begin
                errors++;
                $display("FAIL halt hold %0d: got %h expected %h", i, outv, HLT);
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b0; mem_ready = 1'b0; #1;
        checks++;
        if (outv !== 14'h0) begin
            errors++;
            $display("FAIL halt reset: got %h expected %h", outv, 14'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; #1;
        checks++;
        if (outv !== RD) begin
            errors++;
            $display("FAIL halt exit: got %h expected %h", outv, RD);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        mem_ready = 1'b0;
        instr = '0;
        test_reset();
        test_alu_r();
        test_alu_i();
        test_load_wait();
        test_store();
        test_jump();
        test_illegal_nop();
        test_back_to_back();
        test_store_reset();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
